// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and the round-robin helper for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    // The picker always works on an 8-wide request vector; hosts that do not
    // exist are tied to 0, so scanning modulo 8 yields the same winner as
    // scanning modulo the real host count.
    localparam int unsigned RR_HOSTS = 8;
    localparam int unsigned RR_IDW   = 3;

    // Request fields muxed from the selected host onto the device port.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_req_t;

    // Device response as seen by the arbiter before it is routed to a host.
    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } bus_rsp_t;

    // Returns the first requester found starting at ptr+1 and wrapping.
    // The last index scanned is ptr itself, so the previous winner has the
    // lowest priority. With no request at all, ptr is returned unchanged.
    function automatic logic [RR_IDW-1:0] rr_pick(
        input logic [RR_HOSTS-1:0] req,
        input logic [RR_IDW-1:0]   ptr
    );
        logic [RR_IDW-1:0] idx;
        logic [RR_IDW-1:0] win;
        logic              found;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_HOSTS; i++) begin
            idx = ptr + RR_IDW'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_bus_arb_id_fifo.sv
// Small synchronous FIFO holding the host ID of every granted transaction
// that is still waiting for its in-order device response.
module mem_bus_arb_id_fifo
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wid,
    output logic [WIDTH-1:0]           o_rid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rid     = r_mem[r_rd_ptr];

    // Overflow and underflow are refused here as a second line of defence.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointers wrap at DEPTH, which need not be a power of two.
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    // Storage write; IDs are only read at slots the pointers mark valid.
    // NOTE: the storage array has no reset; after reset the count says it is
    // empty, so stale contents are never observed and the RAM stays plain.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wid;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep the count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port among NHOSTS
// hosts. Requests are forwarded combinationally; responses come back in
// grant order and are steered by the ID FIFO head.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned NHOSTS          = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic [NHOSTS-1:0]        host_req_i,
    input  logic [NHOSTS-1:0]        host_we_i,
    input  logic [NHOSTS-1:0][31:0]  host_addr_i,
    input  logic [NHOSTS-1:0][31:0]  host_wdata_i,
    input  logic [NHOSTS-1:0][3:0]   host_be_i,
    output logic [NHOSTS-1:0]        host_gnt_o,
    output logic [NHOSTS-1:0]        host_rvalid_o,
    output logic [31:0]              host_rdata_o,
    output logic [NHOSTS-1:0]        host_err_o,

    output logic                     dev_req_o,
    output logic                     dev_we_o,
    output logic [31:0]              dev_addr_o,
    output logic [31:0]              dev_wdata_o,
    output logic [3:0]               dev_be_o,
    input  logic                     dev_gnt_i,
    input  logic                     dev_rvalid_i,
    input  logic [31:0]              dev_rdata_i,
    input  logic                     dev_err_i
);

    localparam int unsigned IDW = $clog2(NHOSTS);
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);

    // Arbitration state.
    logic [IDW-1:0]      r_rr_ptr;
    logic                r_lock;
    logic [IDW-1:0]      r_lock_id;

    // Selection and handshake.
    logic [RR_HOSTS-1:0] w_req_pad;
    logic [RR_IDW-1:0]   w_ptr_pad;
    logic [IDW-1:0]      w_pick;
    logic [IDW-1:0]      w_sel;
    logic                w_any_req;
    logic                w_handshake;
    bus_req_t            w_host_req [NHOSTS];
    bus_req_t            w_dev_req;

    // Response side.
    bus_rsp_t            w_dev_rsp;
    logic                w_pop;
    logic [IDW-1:0]      w_head;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;

    // Widen requests and pointer to the picker's fixed 8-host view.
    always_comb begin
        w_req_pad             = '0;
        w_req_pad[NHOSTS-1:0] = host_req_i;
        w_ptr_pad             = '0;
        w_ptr_pad[IDW-1:0]    = r_rr_ptr;
    end

    assign w_pick = IDW'(rr_pick(w_req_pad, w_ptr_pad));

    // A stalled request keeps its host so the device sees stable fields.
    assign w_sel  = r_lock ? r_lock_id : w_pick;

    // Gather each host's request fields so the device mux is a single index.
    always_comb begin
        for (int i = 0; i < NHOSTS; i++) begin
            w_host_req[i].we    = host_we_i[i];
            w_host_req[i].addr  = host_addr_i[i];
            w_host_req[i].wdata = host_wdata_i[i];
            w_host_req[i].be    = host_be_i[i];
        end
    end

    assign w_dev_req   = w_host_req[w_sel];
    assign dev_we_o    = w_dev_req.we;
    assign dev_addr_o  = w_dev_req.addr;
    assign dev_wdata_o = w_dev_req.wdata;
    assign dev_be_o    = w_dev_req.be;

    // Issue is gated by the registered occupancy only, never by dev_gnt_i,
    // so a response in the same cycle cannot open a slot early.
    assign w_any_req   = |host_req_i;
    assign dev_req_o   = w_any_req & ~w_full;
    assign w_handshake = dev_req_o & dev_gnt_i;

    // Responses are only accepted when an ID is waiting for them.
    assign w_dev_rsp    = {dev_rvalid_i, dev_rdata_i, dev_err_i};
    assign w_pop        = w_dev_rsp.rvalid & ~w_empty;
    assign host_rdata_o = w_dev_rsp.rdata;

    // One-hot grant to the selected host and response steering to the head.
    // NOTE: every output of this block gets a default before any condition,
    // which keeps it purely combinational with no inferred latches.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        if (w_handshake) begin
            host_gnt_o[w_sel] = 1'b1;
        end
        if (w_pop) begin
            host_rvalid_o[w_head] = 1'b1;
            host_err_o[w_head]    = w_dev_rsp.err;
        end
    end

    // Pointer advances to the winner on a grant; a stalled request locks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr  <= IDW'(NHOSTS - 1);
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else begin
            if (w_handshake) begin
                r_rr_ptr <= w_sel;
                r_lock   <= 1'b0;
            end else if (dev_req_o) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
            end
        end
    end

    mem_bus_arb_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_handshake),
        .i_pop   (w_pop),
        .i_wid   (w_sel),
        .o_rid   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A response with nothing outstanding means the device broke protocol.
    a_no_orphan_rsp: assert property (
        @(posedge clk_i) disable iff (rst_i) dev_rvalid_i |-> !w_empty
    );

    // Occupancy must never exceed the configured limit.
    a_count_bound: assert property (
        @(posedge clk_i) disable iff (rst_i) w_count <= CW'(MAX_OUTSTANDING)
    );

endmodule
